// File: rtl/conv_result_buffer.sv
// Collects one result per output map into a small buffer, then drains the whole
// frame in ascending index order through a valid/accept handshake.
module conv_result_buffer #(
  parameter int NUM_OUT = 7'd120
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic signed [15:0] add_in,
  input  logic               in_ready,
  input  logic [6:0]         in_ind,
  input  logic               out_accept,
  output logic signed [15:0] out_data,
  output logic [6:0]         out_ind,
  output logic               out_valid,
  output logic               out_last,
  output logic               busy,
  output logic               overrun,
  output logic               bad_ind
);

  localparam logic [7:0] LP_NUM  = 8'(NUM_OUT);
  localparam logic [6:0] LP_LAST = 7'(NUM_OUT - 1);

  typedef enum logic {ST_COLLECT, ST_DRAIN} state_t;

  state_t             r_state;
  logic               r_in_ready_d;
  logic [7:0]         r_count;
  logic [127:0]       r_valid;
  logic [6:0]         r_rd_ptr;
  logic               r_draining;
  logic               r_out_last;
  logic               r_overrun;
  logic               r_bad_ind;
  logic signed [15:0] r_mem [0:127];

  logic       w_cap;
  logic       w_ind_ok;
  logic       w_new;
  logic       w_wr;
  logic [7:0] w_count_inc;
  logic [6:0] w_ptr_inc;

  assign w_cap       = in_ready & ~r_in_ready_d;
  assign w_ind_ok    = ({1'b0, in_ind} < LP_NUM);
  assign w_new       = ~r_valid[in_ind];
  assign w_wr        = (r_state == ST_COLLECT) & w_cap & w_ind_ok;
  assign w_count_inc = r_count + 8'd1;
  assign w_ptr_inc   = r_rd_ptr + 7'd1;

  // Data storage is never cleared; only the per-entry valid bits mark a frame.
  always_ff @(posedge clk_in) begin
    if (w_wr) begin
      r_mem[in_ind] <= add_in;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_COLLECT;
      r_in_ready_d <= 1'b1;
      r_count      <= 8'd0;
      r_valid      <= '0;
      r_rd_ptr     <= 7'd0;
      r_draining   <= 1'b0;
      r_out_last   <= 1'b0;
      r_overrun    <= 1'b0;
      r_bad_ind    <= 1'b0;
    end else begin
      r_in_ready_d <= in_ready;
      case (r_state)
        ST_COLLECT: begin
          if (w_cap) begin
            if (w_ind_ok) begin
              r_valid[in_ind] <= 1'b1;
              // Duplicate indices overwrite data but do not advance the frame.
              if (w_new) begin
                r_count <= w_count_inc;
                if (w_count_inc == LP_NUM) begin
                  r_state    <= ST_DRAIN;
                  r_draining <= 1'b1;
                  r_rd_ptr   <= 7'd0;
                  r_out_last <= (LP_LAST == 7'd0);
                end
              end
            end else begin
              r_bad_ind <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (w_cap) begin
            r_overrun <= 1'b1;
          end
          if (out_accept) begin
            if (r_out_last) begin
              r_state    <= ST_COLLECT;
              r_draining <= 1'b0;
              r_out_last <= 1'b0;
              r_count    <= 8'd0;
              r_valid    <= '0;
              r_rd_ptr   <= 7'd0;
            end else begin
              r_rd_ptr   <= w_ptr_inc;
              r_out_last <= (w_ptr_inc == LP_LAST);
            end
          end
        end
        default: r_state <= ST_COLLECT;
      endcase
    end
  end

  assign out_data  = r_draining ? r_mem[r_rd_ptr] : 16'sd0;
  assign out_ind   = r_rd_ptr;
  assign out_valid = r_draining;
  assign busy      = r_draining;
  assign out_last  = r_out_last;
  assign overrun   = r_overrun;
  assign bad_ind   = r_bad_ind;

endmodule
